// File: rtl/wb_arbiter.sv
// Writeback arbiter: NSRC execution pipelines share one scalar and one vector
// register-file write port. Each source has an in-order FIFO plus a zero-latency bypass.
module wb_arbiter #(
  parameter int NSRC    = 2,
  parameter int DATA_W  = 36,
  parameter int VDATA_W = 128,
  parameter int LANES   = 4,
  parameter int REG_AW  = 5,
  parameter int DEPTH   = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NSRC-1:0]                   src_valid,
  output logic [NSRC-1:0]                   src_ready,
  input  logic [NSRC-1:0]                   src_is_vec,
  input  logic [NSRC*REG_AW-1:0]            src_wbr,
  input  logic [NSRC*DATA_W-1:0]            src_data,
  input  logic [NSRC*VDATA_W-1:0]           src_vdata,
  input  logic [NSRC*LANES-1:0]             src_mask,
  output logic                              register_we,
  output logic [REG_AW-1:0]                 register_wbr,
  output logic [DATA_W-1:0]                 register_data,
  output logic [LANES-1:0]                  vector_we,
  output logic [REG_AW-1:0]                 vector_wbr,
  output logic [VDATA_W-1:0]                vector_data,
  output logic [NSRC*($clog2(DEPTH)+1)-1:0] buf_count,
  output logic [NSRC-1:0]                   overflow_err
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IDX_W = $clog2(NSRC);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSRC - 1);

  typedef struct packed {
    logic               is_vec;
    logic [REG_AW-1:0]  wbr;
    logic [DATA_W-1:0]  data;
    logic [VDATA_W-1:0] vdata;
    logic [LANES-1:0]   mask;
  } ent_t;

  ent_t             mem_q    [NSRC][DEPTH];
  ent_t             in_ent   [NSRC];
  ent_t             head     [NSRC];
  logic [CNT_W-1:0] cnt_q    [NSRC];
  logic [CNT_W-1:0] cnt_d    [NSRC];
  logic [PTR_W-1:0] rd_ptr_q [NSRC];
  logic [PTR_W-1:0] rd_ptr_d [NSRC];
  logic [PTR_W-1:0] wr_ptr_q [NSRC];
  logic [PTR_W-1:0] wr_ptr_d [NSRC];

  logic [NSRC-1:0]  head_vld, req_s, req_v, gnt, acc, push, pop;
  logic [NSRC-1:0]  ovf_q, ovf_d;
  logic [IDX_W-1:0] rr_s_q, rr_s_d, rr_v_q, rr_v_d, gidx_s, gidx_v;
  logic             found_s, found_v;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] p);
    return (p == IDX_LAST) ? '0 : p + IDX_W'(1);
  endfunction

  // Returns {found, index}: first requester at or above ptr, else first below it.
  function automatic logic [IDX_W:0] rr_pick(input logic [NSRC-1:0] req,
                                             input logic [IDX_W-1:0] ptr);
    logic [IDX_W:0] res;
    res = '0;
    for (int i = 0; i < NSRC; i++)
      if (!res[IDX_W] && req[i] && (IDX_W'(i) >= ptr)) res = {1'b1, IDX_W'(i)};
    for (int i = 0; i < NSRC; i++)
      if (!res[IDX_W] && req[i] && (IDX_W'(i) < ptr)) res = {1'b1, IDX_W'(i)};
    return res;
  endfunction

  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      src_ready[i]     = (cnt_q[i] < CNT_FULL);
      in_ent[i].is_vec = src_is_vec[i];
      in_ent[i].wbr    = src_wbr[i*REG_AW +: REG_AW];
      in_ent[i].data   = src_data[i*DATA_W +: DATA_W];
      in_ent[i].vdata  = src_vdata[i*VDATA_W +: VDATA_W];
      in_ent[i].mask   = src_mask[i*LANES +: LANES];
      // No grants while in reset, so buffered entries are discarded unwritten.
      if (cnt_q[i] != '0) begin
        head[i]     = mem_q[i][rd_ptr_q[i]];
        head_vld[i] = !rst;
      end else begin
        head[i]     = in_ent[i];
        head_vld[i] = src_valid[i] && !rst;
      end
      req_s[i] = head_vld[i] && !head[i].is_vec;
      req_v[i] = head_vld[i] && head[i].is_vec;
    end

    {found_s, gidx_s} = rr_pick(req_s, rr_s_q);
    {found_v, gidx_v} = rr_pick(req_v, rr_v_q);

    register_we   = found_s;
    register_wbr  = '0;
    register_data = '0;
    if (found_s) begin
      register_wbr  = head[gidx_s].wbr;
      register_data = head[gidx_s].data;
    end
    vector_we   = '0;
    vector_wbr  = '0;
    vector_data = '0;
    if (found_v) begin
      vector_we   = head[gidx_v].mask;
      vector_wbr  = head[gidx_v].wbr;
      vector_data = head[gidx_v].vdata;
    end

    rr_s_d = found_s ? idx_inc(gidx_s) : rr_s_q;
    rr_v_d = found_v ? idx_inc(gidx_v) : rr_v_q;

    for (int i = 0; i < NSRC; i++) begin
      gnt[i]  = (found_s && (gidx_s == IDX_W'(i))) || (found_v && (gidx_v == IDX_W'(i)));
      acc[i]  = src_valid[i] && src_ready[i];
      pop[i]  = gnt[i] && (cnt_q[i] != '0);
      // A granted bypass consumes the incoming result without storing it.
      push[i] = acc[i] && !(gnt[i] && (cnt_q[i] == '0));
      cnt_d[i] = cnt_q[i];
      if (push[i] && !pop[i])      cnt_d[i] = cnt_q[i] + CNT_W'(1);
      else if (pop[i] && !push[i]) cnt_d[i] = cnt_q[i] - CNT_W'(1);
      rd_ptr_d[i] = pop[i]  ? ptr_inc(rd_ptr_q[i]) : rd_ptr_q[i];
      wr_ptr_d[i] = push[i] ? ptr_inc(wr_ptr_q[i]) : wr_ptr_q[i];
      ovf_d[i]    = ovf_q[i] | (src_valid[i] & ~src_ready[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NSRC; i++) begin
        cnt_q[i]    <= '0;
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
      end
      rr_s_q <= '0;
      rr_v_q <= '0;
      ovf_q  <= '0;
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        cnt_q[i]    <= cnt_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        wr_ptr_q[i] <= wr_ptr_d[i];
      end
      rr_s_q <= rr_s_d;
      rr_v_q <= rr_v_d;
      ovf_q  <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NSRC; i++)
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= in_ent[i];
  end

  for (genvar g = 0; g < NSRC; g++) begin : g_cnt
    assign buf_count[g*CNT_W +: CNT_W] = cnt_q[g];
  end
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a vector table with hand-computed results,
// then a long contended scalar run checked against a queue-based reference.
module tb_wb_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   src_valid, src_ready, src_is_vec, overflow_err;
  logic [9:0]   src_wbr;
  logic [71:0]  src_data;
  logic [255:0] src_vdata;
  logic [7:0]   src_mask;
  logic         register_we;
  logic [4:0]   register_wbr, vector_wbr;
  logic [35:0]  register_data;
  logic [3:0]   vector_we;
  logic [127:0] vector_data;
  logic [5:0]   buf_count;

  wb_arbiter #(.NSRC(2), .DATA_W(36), .VDATA_W(128), .LANES(4), .REG_AW(5), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_ready(src_ready), .src_is_vec(src_is_vec),
    .src_wbr(src_wbr), .src_data(src_data), .src_vdata(src_vdata), .src_mask(src_mask),
    .register_we(register_we), .register_wbr(register_wbr), .register_data(register_data),
    .vector_we(vector_we), .vector_wbr(vector_wbr), .vector_data(vector_data),
    .buf_count(buf_count), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [1:0]  vld, isv;
    logic [4:0]  w0, w1;
    logic [35:0] d0, d1;
    logic [3:0]  m1;
    logic        e_rwe;
    logic [4:0]  e_rwbr;
    logic [35:0] e_rdata;
    logic [3:0]  e_vwe;
    logic [4:0]  e_vwbr;
    logic [35:0] e_vd;
    logic [1:0]  e_rdy;
    logic [2:0]  e_c0, e_c1;
    logic [1:0]  e_ovf;
  } vec_t;

  localparam int NV = 17;
  vec_t tv [NV];
  int total = 0;
  int bad   = 0;

  function automatic vec_t mk(longint r, longint vld, longint isv, longint w0, longint w1,
                              longint d0, longint d1, longint m1, longint rwe, longint rwbr,
                              longint rdata, longint vwe, longint vwbr, longint vd,
                              longint rdy, longint c0, longint c1, longint ovf);
    vec_t v;
    v.rst = 1'(r);       v.vld = 2'(vld);     v.isv = 2'(isv);
    v.w0 = 5'(w0);       v.w1 = 5'(w1);       v.d0 = 36'(d0);      v.d1 = 36'(d1);
    v.m1 = 4'(m1);       v.e_rwe = 1'(rwe);   v.e_rwbr = 5'(rwbr); v.e_rdata = 36'(rdata);
    v.e_vwe = 4'(vwe);   v.e_vwbr = 5'(vwbr); v.e_vd = 36'(vd);    v.e_rdy = 2'(rdy);
    v.e_c0 = 3'(c0);     v.e_c1 = 3'(c1);     v.e_ovf = 2'(ovf);
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s [%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive_idle();
    src_valid = '0; src_is_vec = '0; src_wbr = '0; src_data = '0; src_vdata = '0; src_mask = '0;
  endtask

  logic [35:0] q0[$], q1[$];
  logic [35:0] in0, in1, h0, h1;
  logic        v0, v1, h0v, h1v, acc0, acc1;
  logic [1:0]  ovf_m;
  int          g, rr, s0, s1;

  initial begin
    //             rst vld  isv  w0 w1 d0            d1      m1    rwe rwbr rdata         vwe   vwbr vd      rdy  c0 c1 ovf
    tv[0]  = mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0,                    0, 0, 0,                0, 0, 0,          2'b11, 0, 0, 2'b00);
    tv[1]  = mk(0, 2'b01, 2'b00, 3, 0, 36'h123456789, 0, 0,        1, 3, 36'h123456789,    0, 0, 0,          2'b11, 0, 0, 2'b00);
    tv[2]  = mk(1, 2'b00, 2'b00, 0, 0, 0, 0, 0,                    0, 0, 0,                0, 0, 0,          2'b11, 0, 0, 2'b00);
    tv[3]  = mk(0, 2'b11, 2'b00, 10, 20, 36'h100, 36'h200, 0,      1, 10, 36'h100,         0, 0, 0,          2'b11, 0, 0, 2'b00);
    tv[4]  = mk(0, 2'b11, 2'b00, 11, 21, 36'h101, 36'h201, 0,      1, 20, 36'h200,         0, 0, 0,          2'b11, 0, 1, 2'b00);
    tv[5]  = mk(0, 2'b11, 2'b00, 12, 22, 36'h102, 36'h202, 0,      1, 11, 36'h101,         0, 0, 0,          2'b11, 1, 1, 2'b00);
    tv[6]  = mk(0, 2'b11, 2'b00, 13, 23, 36'h103, 36'h203, 0,      1, 21, 36'h201,         0, 0, 0,          2'b11, 1, 2, 2'b00);
    tv[7]  = mk(0, 2'b11, 2'b00, 14, 24, 36'h104, 36'h204, 0,      1, 12, 36'h102,         0, 0, 0,          2'b11, 2, 2, 2'b00);
    tv[8]  = mk(0, 2'b11, 2'b00, 15, 25, 36'h105, 36'h205, 0,      1, 22, 36'h202,         0, 0, 0,          2'b11, 2, 3, 2'b00);
    tv[9]  = mk(0, 2'b11, 2'b00, 16, 26, 36'h106, 36'h206, 0,      1, 13, 36'h103,         0, 0, 0,          2'b11, 3, 3, 2'b00);
    tv[10] = mk(0, 2'b11, 2'b00, 17, 27, 36'h107, 36'h207, 0,      1, 23, 36'h203,         0, 0, 0,          2'b01, 3, 4, 2'b00);
    tv[11] = mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0,                    1, 14, 36'h104,         0, 0, 0,          2'b10, 4, 3, 2'b10);
    tv[12] = mk(1, 2'b00, 2'b00, 0, 0, 0, 0, 0,                    0, 0, 0,                0, 0, 0,          2'b11, 3, 3, 2'b10);
    tv[13] = mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0,                    0, 0, 0,                0, 0, 0,          2'b11, 0, 0, 2'b00);
    tv[14] = mk(0, 2'b11, 2'b10, 1, 2, 36'h55, 36'hABC, 4'b0101,   1, 1, 36'h55,           4'b0101, 2, 36'hABC, 2'b11, 0, 0, 2'b00);
    tv[15] = mk(0, 2'b10, 2'b10, 0, 7, 0, 36'h77, 4'b0000,         0, 0, 0,                4'b0000, 7, 36'h77,  2'b11, 0, 0, 2'b00);
    tv[16] = mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0,                    0, 0, 0,                0, 0, 0,          2'b11, 0, 0, 2'b00);

    rst = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      rst        = tv[i].rst;
      src_valid  = tv[i].vld;
      src_is_vec = tv[i].isv;
      src_wbr    = {tv[i].w1, tv[i].w0};
      src_data   = {tv[i].d1, tv[i].d0};
      src_vdata  = {92'h0, tv[i].d1, 92'h0, tv[i].d0};
      src_mask   = {tv[i].m1, 4'h0};
      #1;
      chk("register_we",   i, 128'(register_we),   128'(tv[i].e_rwe));
      chk("register_wbr",  i, 128'(register_wbr),  128'(tv[i].e_rwbr));
      chk("register_data", i, 128'(register_data), 128'(tv[i].e_rdata));
      chk("vector_we",     i, 128'(vector_we),     128'(tv[i].e_vwe));
      chk("vector_wbr",    i, 128'(vector_wbr),    128'(tv[i].e_vwbr));
      chk("vector_data",   i, vector_data,         {92'h0, tv[i].e_vd});
      chk("src_ready",     i, 128'(src_ready),     128'(tv[i].e_rdy));
      chk("buf_count",     i, 128'(buf_count),     128'({tv[i].e_c1, tv[i].e_c0}));
      chk("overflow_err",  i, 128'(overflow_err),  128'(tv[i].e_ovf));
      @(negedge clk);
    end

    // Long contended scalar run: both sources stream, fill, overflow, wrap and drain.
    rst = 1'b1;
    drive_idle();
    @(negedge clk);
    rst   = 1'b0;
    rr    = 0;
    ovf_m = '0;
    q0.delete();
    q1.delete();
    for (int c = 0; c < 34; c++) begin
      if (c != 0) @(negedge clk);
      v0  = (c < 22);
      v1  = (c < 22) && (c % 5 != 3);
      in0 = {4'h0, 32'(c)};
      in1 = {4'h1, 32'(c)};
      src_valid  = {v1, v0};
      src_is_vec = '0;
      src_wbr    = {5'(c + 1), 5'(c)};
      src_data   = {in1, in0};
      src_vdata  = '0;
      src_mask   = '0;
      s0  = q0.size();
      s1  = q1.size();
      h0v = (s0 > 0) || v0;
      h1v = (s1 > 0) || v1;
      h0  = (s0 > 0) ? q0[0] : in0;
      h1  = (s1 > 0) ? q1[0] : in1;
      if (rr == 0) g = h0v ? 0 : (h1v ? 1 : -1);
      else         g = h1v ? 1 : (h0v ? 0 : -1);
      #1;
      chk("seq_we",  c, 128'(register_we), 128'(g >= 0));
      if (g >= 0) chk("seq_data", c, 128'(register_data), 128'((g == 0) ? h0 : h1));
      chk("seq_ready", c, 128'(src_ready), 128'({s1 < 4, s0 < 4}));
      chk("seq_count", c, 128'(buf_count), 128'({3'(s1), 3'(s0)}));
      chk("seq_ovf",   c, 128'(overflow_err), 128'(ovf_m));
      acc0 = v0 && (s0 < 4);
      acc1 = v1 && (s1 < 4);
      if (g == 0 && s0 > 0) void'(q0.pop_front());
      if (g == 1 && s1 > 0) void'(q1.pop_front());
      if (acc0 && !(g == 0 && s0 == 0)) q0.push_back(in0);
      if (acc1 && !(g == 1 && s1 == 0)) q1.push_back(in1);
      if (v0 && !acc0) ovf_m[0] = 1'b1;
      if (v1 && !acc1) ovf_m[1] = 1'b1;
      if (g >= 0) rr = (g + 1) % 2;
    end
    @(negedge clk);
    chk("drained", 0, 128'(buf_count), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
